// File: rtl/next_pc_unit_pkg.sv
// rtl/next_pc_unit_pkg.sv - shared state encoding and constants for the PC stage
package next_pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_STEP            = 32'd4;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - combinational next-PC target select and alignment check
module next_pc_mux
  import next_pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        Branch,
  input  logic        BranchNe,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] Addresult,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_value,
  output logic [31:0] pcincrementado,
  output logic [31:0] target,
  output logic        misaligned
);

  logic        taken;
  logic [31:0] jump_target;

  assign pcincrementado = pc + PC_STEP;
  assign taken          = (Branch & Zero) | (BranchNe & ~Zero);
  assign jump_target    = {pcincrementado[31:28], instr_index, 2'b00};

  // jr beats j beats a taken branch; simultaneous strobes resolve only here
  always_comb begin
    target = pcincrementado;
    if (JumpReg) begin
      target = rs_value;
    end else if (Jump) begin
      target = jump_target;
    end else if (taken) begin
      target = Addresult;
    end
  end

  assign misaligned = word_misaligned(target[1:0]);

endmodule

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - PC register, boot/run/trap FSM and EPC capture
// Optional branch/jump statistics counters: NEXT_PC_BRANCH_STATS_EN
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        Branch,
  input  logic        BranchNe,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] Addresult,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_value,
  output logic [31:0] pc,
  output logic [31:0] pcincrementado,
  output logic        fetch_valid,
  output logic        trap,
  output logic [31:0] epc,
  output logic        double_fault,
  output logic [31:0] taken_count,
  output logic [31:0] jump_count
);

  pc_state_t   state, state_nx;
  logic [31:0] pc_nx, epc_nx, target;
  logic        double_fault_nx, misaligned;

  next_pc_mux u_mux (
    .pc             (pc),
    .Branch         (Branch),
    .BranchNe       (BranchNe),
    .Zero           (Zero),
    .Jump           (Jump),
    .JumpReg        (JumpReg),
    .Addresult      (Addresult),
    .instr_index    (instr_index),
    .rs_value       (rs_value),
    .pcincrementado (pcincrementado),
    .target         (target),
    .misaligned     (misaligned)
  );

  assign fetch_valid = (state != ST_BOOT);
  assign trap        = (state == ST_TRAP);

  // ST_BOOT leaves on the first edge even when stalled; pc is already RESET_PC
  always_comb begin
    state_nx        = state;
    pc_nx           = pc;
    epc_nx          = epc;
    double_fault_nx = double_fault;
    case (state)
      ST_BOOT: state_nx = ST_RUN;
      ST_RUN: begin
        if (pc_write) begin
          if (misaligned) begin
            pc_nx    = EXC_VECTOR;
            epc_nx   = pc;
            state_nx = ST_TRAP;
          end else begin
            pc_nx = target;
          end
        end
      end
      ST_TRAP: begin
        if (pc_write) begin
          if (misaligned) begin
            pc_nx           = EXC_VECTOR;
            double_fault_nx = 1'b1;
          end else begin
            pc_nx    = target;
            state_nx = ST_RUN;
          end
        end
      end
      default: state_nx = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_BOOT;
      pc           <= RESET_PC;
      epc          <= '0;
      double_fault <= 1'b0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      epc          <= epc_nx;
      double_fault <= double_fault_nx;
    end
  end

`ifdef NEXT_PC_BRANCH_STATS_EN
  logic commit, branch_hit, jump_hit;

  // Counted on commit even when the selected target traps
  assign commit     = pc_write & (state != ST_BOOT);
  assign branch_hit = ((Branch & Zero) | (BranchNe & ~Zero)) & ~Jump & ~JumpReg;
  assign jump_hit   = Jump | JumpReg;

  always_ff @(posedge clock) begin
    if (reset) begin
      taken_count <= '0;
      jump_count  <= '0;
    end else if (commit) begin
      if (branch_hit && (taken_count != 32'hFFFF_FFFF)) taken_count <= taken_count + 32'd1;
      if (jump_hit && (jump_count != 32'hFFFF_FFFF)) jump_count <= jump_count + 32'd1;
    end
  end
`else
  assign taken_count = '0;
  assign jump_count  = '0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - directed plus randomized check of next_pc_unit against a behavioural model
module tb_next_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC = 32'h0000_0080;

  logic        clock = 1'b0;
  logic        reset, pc_write, Branch, BranchNe, Zero, Jump, JumpReg;
  logic [31:0] Addresult, rs_value;
  logic [25:0] instr_index;
  logic [31:0] pc, pcincrementado, epc, taken_count, jump_count;
  logic        fetch_valid, trap, double_fault;

  always #5 clock = ~clock;

  next_pc_unit dut (
    .clock          (clock),
    .reset          (reset),
    .pc_write       (pc_write),
    .Branch         (Branch),
    .BranchNe       (BranchNe),
    .Zero           (Zero),
    .Jump           (Jump),
    .JumpReg        (JumpReg),
    .Addresult      (Addresult),
    .instr_index    (instr_index),
    .rs_value       (rs_value),
    .pc             (pc),
    .pcincrementado (pcincrementado),
    .fetch_valid    (fetch_valid),
    .trap           (trap),
    .epc            (epc),
    .double_fault   (double_fault),
    .taken_count    (taken_count),
    .jump_count     (jump_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Behavioural model: booting/in_trap flags rather than a state code
  logic [31:0] m_pc, m_epc, m_tc, m_jc;
  bit          m_booting, m_in_trap, m_df;

  task automatic model_edge();
    logic [31:0] nxt, dest;
    bit          br_taken;
    if (reset) begin
      m_pc = RST_PC; m_epc = 0; m_booting = 1; m_in_trap = 0; m_df = 0; m_tc = 0; m_jc = 0;
      return;
    end
    if (m_booting) begin
      m_booting = 0;
      return;
    end
    if (!pc_write) return;
    nxt      = m_pc + 32'd4;
    br_taken = (Branch && Zero) || (BranchNe && !Zero);
    if (JumpReg)       dest = rs_value;
    else if (Jump)     dest = {nxt[31:28], instr_index, 2'b00};
    else if (br_taken) dest = Addresult;
    else               dest = nxt;
    if (dest % 4 != 0) begin
      if (m_in_trap) m_df = 1;
      else m_epc = m_pc;
      m_pc = EXC_PC;
      m_in_trap = 1;
    end else begin
      m_pc = dest;
      m_in_trap = 0;
    end
`ifdef NEXT_PC_BRANCH_STATS_EN
    if (br_taken && !Jump && !JumpReg && m_tc != 32'hFFFF_FFFF) m_tc++;
    if ((Jump || JumpReg) && m_jc != 32'hFFFF_FFFF) m_jc++;
`endif
  endtask

  task automatic check_model();
    check("pc", pc, m_pc);
    check("pcinc", pcincrementado, m_pc + 32'd4);
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, !m_booting});
    check("trap", {31'd0, trap}, {31'd0, m_in_trap});
    check("epc", epc, m_epc);
    check("double_fault", {31'd0, double_fault}, {31'd0, m_df});
    check("taken_count", taken_count, m_tc);
    check("jump_count", jump_count, m_jc);
  endtask

  // Inputs are already driven; settle, compare, then advance both model and DUT
  task automatic cycle();
    #1;
    check_model();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    pc_write = 1; Branch = 0; BranchNe = 0; Zero = 0; Jump = 0; JumpReg = 0;
    Addresult = 0; instr_index = 0; rs_value = 0;
  endtask

  task automatic go_to(input logic [31:0] addr);
    idle(); JumpReg = 1; rs_value = addr; cycle(); idle();
  endtask

  task automatic do_reset();
    idle(); reset = 1; cycle(); reset = 0;
  endtask

  logic [31:0] boot_seq [5];

  initial begin
    reset = 1; idle();
    m_pc = 0; m_epc = 0; m_tc = 0; m_jc = 0; m_booting = 1; m_in_trap = 0; m_df = 0;
    @(posedge clock); #1;
    cycle();
    check("rst_pc", pc, 32'h0);
    check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_df", {31'd0, double_fault}, 32'd0);
    reset = 0;

    boot_seq = '{32'd0, 32'd0, 32'd4, 32'd8, 32'd12};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("boot_pc%0d", i), pc, boot_seq[i]);
      if (i < 4) cycle();
    end
    pc_write = 0; cycle(); cycle();
    check("stall_pc", pc, 32'd12);
    idle();

    go_to(40);
    Branch = 1; Zero = 1; Addresult = 240; cycle();
    check("beq_taken", pc, 32'd240);
    go_to(40);
    Branch = 1; Zero = 0; Addresult = 240; cycle();
    check("beq_not_taken", pc, 32'd44);
    idle(); BranchNe = 1; Zero = 0; Addresult = 60; cycle();
    check("bne_taken", pc, 32'd60);

    go_to(32'h1000_0010);
    Jump = 1; instr_index = 26'h0000040; cycle();
    check("jump", pc, 32'h1000_0100);
    go_to(32'h1000_0010);
    Jump = 1; instr_index = 26'h0000040; JumpReg = 1; rs_value = 32'h400; cycle();
    check("jr_priority", pc, 32'h400);

    go_to(48);
    JumpReg = 1; rs_value = 32'h202; cycle();
    check("trap_pc", pc, EXC_PC);
    check("trap_epc", epc, 32'd48);
    check("trap_pulse", {31'd0, trap}, 32'd1);
    idle(); cycle();
    check("post_trap_pc", pc, 32'h84);
    check("post_trap_clear", {31'd0, trap}, 32'd0);

    JumpReg = 1; rs_value = 32'h202; cycle();
    idle(); pc_write = 0; cycle();
    check("trap_stall_hold", {31'd0, trap}, 32'd1);
    idle(); Branch = 1; Zero = 1; Addresult = 32'h91; cycle();
    check("df_pc", pc, EXC_PC);
    check("df_epc", epc, 32'h84);
    check("df_flag", {31'd0, double_fault}, 32'd1);
    do_reset();
    check("reset_mid_trap_pc", pc, 32'h0);
    check("reset_mid_trap_df", {31'd0, double_fault}, 32'd0);
    check("reset_mid_trap_fv", {31'd0, fetch_valid}, 32'd0);
    cycle();

    go_to(32'hFFFF_FFFC);
    #1 check("wrap_pcinc", pcincrementado, 32'h0);
    cycle();
    check("wrap_pc", pc, 32'h0);

    do_reset(); cycle();
    for (int i = 1; i <= 3; i++) begin
      idle(); Branch = 1; Zero = 1; Addresult = 32'h100 * i; cycle();
    end
    idle(); Jump = 1; instr_index = 26'd5; cycle();
    idle(); JumpReg = 1; rs_value = 32'h40; cycle();
    idle();
`ifdef NEXT_PC_BRANCH_STATS_EN
    check("stats_taken", taken_count, 32'd3);
    check("stats_jump", jump_count, 32'd2);
`else
    check("stats_taken_off", taken_count, 32'd0);
    check("stats_jump_off", jump_count, 32'd0);
`endif

    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      pc_write    = ($urandom_range(0, 4) != 0);
      Branch      = $urandom_range(0, 2) == 0;
      BranchNe    = $urandom_range(0, 3) == 0;
      Zero        = $urandom_range(0, 1) == 1;
      Jump        = $urandom_range(0, 5) == 0;
      JumpReg     = $urandom_range(0, 6) == 0;
      instr_index = 26'($urandom);
      Addresult   = $urandom & 32'hFFFF_FFFC;
      rs_value    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) Addresult[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) rs_value[1:0]  = 2'($urandom_range(1, 3));
      cycle();
    end
    reset = 0; idle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
